// File: rtl/tone_mixer_if.sv
// tone_mixer_if: codec sample handshake and stereo sample bus between Audio_Controller and tone_mixer
interface tone_mixer_if #(
    parameter int SAMPLE_W = 32
);
    logic                audio_in_available;
    logic                audio_out_allowed;
    logic                read_audio_in;
    logic                write_audio_out;
    logic [SAMPLE_W-1:0] left_in;
    logic [SAMPLE_W-1:0] right_in;
    logic [SAMPLE_W-1:0] left_out;
    logic [SAMPLE_W-1:0] right_out;
    modport master (
        output audio_in_available, audio_out_allowed, left_in, right_in,
        input  read_audio_in, write_audio_out, left_out, right_out
    );
    modport slave (
        input  audio_in_available, audio_out_allowed, left_in, right_in,
        output read_audio_in, write_audio_out, left_out, right_out
    );
endinterface

// File: rtl/tone_mixer.sv
// tone_mixer: multi-voice square-wave tone generator, summed and added with saturation to the codec stream
module tone_mixer #(
    parameter int                NUM_VOICES = 2,
    parameter int                SEL_W      = 4,
    parameter int                BASE_W     = 15,
    parameter logic [BASE_W-1:0] BASE_HALF  = 15'd3000,
    parameter logic [31:0]       AMP        = 32'd10000000,
    parameter int                SAMPLE_W   = 32,
    parameter int                DUR_W      = 26
) (
    input  logic                        CLOCK_50,
    input  logic                        resetn,
    input  logic [NUM_VOICES*SEL_W-1:0] voice_sel,
    input  logic [NUM_VOICES-1:0]       voice_trig,
    input  logic [DUR_W-1:0]            voice_dur,
    output logic [NUM_VOICES-1:0]       voice_active,
    tone_mixer_if.slave                 codec
);
    localparam int PW = SEL_W + BASE_W;
    localparam int MW = SAMPLE_W + 4;
    localparam int OW = SAMPLE_W + 5;
    localparam logic signed [MW-1:0] AMP_S  = MW'(AMP);
    localparam logic signed [OW-1:0] SAT_HI = {{(OW-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
    localparam logic signed [OW-1:0] SAT_LO = {{(OW-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

    typedef enum logic {IDLE, PLAY} state_t;

    logic signed [MW-1:0] contrib [NUM_VOICES];
    logic signed [MW-1:0] mix_q, mix_d;
    logic signed [OW-1:0] left_sum, right_sum;

    for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
        state_t           state_q, state_d;
        logic [PW-1:0]    phase_q, phase_d;
        logic             sq_q, sq_d;
        logic [DUR_W-1:0] dur_q, dur_d;
        logic [SEL_W-1:0] sel;
        logic [PW-1:0]    half;
        logic             wrap;
        assign sel  = voice_sel[v*SEL_W +: SEL_W];
        assign half = {sel, BASE_HALF};
        assign wrap = phase_q >= half;
        always_comb begin
            state_d = state_q;
            phase_d = phase_q;
            sq_d    = sq_q;
            dur_d   = dur_q;
            if (voice_trig[v]) begin
                state_d = (sel != '0) ? PLAY : IDLE;
                phase_d = '0;
                sq_d    = (sel != '0);
                dur_d   = (sel != '0) ? voice_dur : '0;
            end else if (state_q == PLAY) begin
                if (sel == '0 || dur_q == DUR_W'(1)) begin
                    state_d = IDLE;
                    phase_d = '0;
                    sq_d    = 1'b0;
                    dur_d   = '0;
                end else begin
                    // a shrunken half-period simply wraps on the next clock
                    phase_d = wrap ? '0 : phase_q + PW'(1);
                    sq_d    = wrap ? ~sq_q : sq_q;
                    dur_d   = (dur_q != '0) ? dur_q - DUR_W'(1) : dur_q;
                end
            end
        end
        always_ff @(posedge CLOCK_50 or negedge resetn) begin
            if (!resetn) begin
                state_q <= IDLE;
                phase_q <= '0;
                sq_q    <= 1'b0;
                dur_q   <= '0;
            end else begin
                state_q <= state_d;
                phase_q <= phase_d;
                sq_q    <= sq_d;
                dur_q   <= dur_d;
            end
        end
        assign voice_active[v] = (state_q == PLAY);
        assign contrib[v]      = (state_q == PLAY) ? (sq_q ? AMP_S : -AMP_S) : '0;
    end

    always_comb begin
        mix_d = '0;
        for (int i = 0; i < NUM_VOICES; i++) mix_d = mix_d + contrib[i];
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) mix_q <= '0;
        else mix_q <= mix_d;
    end

    assign left_sum  = OW'(signed'(codec.left_in)) + OW'(mix_q);
    assign right_sum = OW'(signed'(codec.right_in)) + OW'(mix_q);
    assign codec.left_out  = (left_sum > SAT_HI) ? SAT_HI[SAMPLE_W-1:0] :
                             (left_sum < SAT_LO) ? SAT_LO[SAMPLE_W-1:0] : left_sum[SAMPLE_W-1:0];
    assign codec.right_out = (right_sum > SAT_HI) ? SAT_HI[SAMPLE_W-1:0] :
                             (right_sum < SAT_LO) ? SAT_LO[SAMPLE_W-1:0] : right_sum[SAMPLE_W-1:0];
    assign codec.read_audio_in   = codec.audio_in_available & codec.audio_out_allowed;
    assign codec.write_audio_out = codec.audio_in_available & codec.audio_out_allowed;
endmodule

// File: tb/tb_tone_mixer.sv
// tb_tone_mixer: vector table, directed corner sequences and random stimulus against a closed-form tone model
module tb_tone_mixer;
    localparam longint AMP  = 10000000;
    localparam longint SMAX = 64'sh7FFF_FFFF;
    localparam longint SMIN = -64'sh8000_0000;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic [7:0]  sel = '0, sel2 = '0;
    logic [1:0]  trig = '0, trig2 = '0, act, act2;
    logic [25:0] dur = '0, dur2 = '0;

    tone_mixer_if #(.SAMPLE_W(32)) bus ();
    tone_mixer_if #(.SAMPLE_W(32)) bus2 ();

    // small half-period base keeps the bulk of the run short: H = sel*16 + 5
    tone_mixer #(.BASE_W(4), .BASE_HALF(4'd5)) dut (
        .CLOCK_50(clk), .resetn(resetn), .voice_sel(sel), .voice_trig(trig),
        .voice_dur(dur), .voice_active(act), .codec(bus)
    );
    tone_mixer dut2 (
        .CLOCK_50(clk), .resetn(resetn), .voice_sel(sel2), .voice_trig(trig2),
        .voice_dur(dur2), .voice_active(act2), .codec(bus2)
    );

    always #5 clk = ~clk;

    int     n_cmp = 0, n_fail = 0;
    longint cyc = 0, m_mix = 0;
    longint m_start[2], m_dur[2];
    int     m_sel[2];
    bit     m_play[2], m_act[2], m_sq[2];

    typedef struct {
        logic        av;
        logic        al;
        logic [31:0] lin;
        logic        exp_hs;
        logic [31:0] exp_out;
    } vec_t;
    vec_t vt[7];

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, got, exp);
        end
    endtask

    function automatic logic [31:0] sat(input logic [31:0] x);
        longint s;
        s = longint'($signed(x)) + m_mix;
        return (s > SMAX) ? 32'h7FFF_FFFF : (s < SMIN) ? 32'h8000_0000 : s[31:0];
    endfunction

    task automatic model_reset();
        m_mix = 0;
        for (int i = 0; i < 2; i++) begin
            m_play[i]  = 0;
            m_act[i]   = 0;
            m_sq[i]    = 0;
            m_start[i] = 0;
            m_dur[i]   = 0;
            m_sel[i]   = 0;
        end
    endtask

    // voice state after an edge: k clocks since the trig edge, square high during even half-periods
    task automatic model_edge();
        longint k;
        int s;
        m_mix = 0;
        for (int i = 0; i < 2; i++) if (m_act[i]) m_mix += m_sq[i] ? AMP : -AMP;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            s = int'(sel[i*4 +: 4]);
            if (trig[i]) begin
                m_play[i]  = (s != 0);
                m_start[i] = cyc;
                m_dur[i]   = longint'(dur);
                m_sel[i]   = s;
            end else if (s == 0) m_play[i] = 0;
            k = cyc - m_start[i];
            if (m_dur[i] != 0 && k >= m_dur[i]) m_play[i] = 0;
            m_act[i] = m_play[i];
            m_sq[i]  = ((k / longint'(m_sel[i] * 16 + 6)) % 2) == 0;
        end
    endtask

    task automatic check_all();
        chk("active", act, {m_act[1], m_act[0]});
        chk("left", bus.left_out, sat(bus.left_in));
        chk("right", bus.right_out, sat(bus.right_in));
        chk("hs_read", bus.read_audio_in, bus.audio_in_available & bus.audio_out_allowed);
        chk("hs_write", bus.write_audio_out, bus.audio_in_available & bus.audio_out_allowed);
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        trig = '0;
    endtask

    initial begin
        int cnt;
        logic [31:0] r;
        vt[0] = '{1'b1, 1'b1, 32'h0000_0000, 1'b1, 32'h0098_9680};
        vt[1] = '{1'b1, 1'b0, 32'h7FFF_0000, 1'b0, 32'h7FFF_FFFF};
        vt[2] = '{1'b0, 1'b1, 32'h7F00_0000, 1'b0, 32'h7F98_9680};
        vt[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 1'b0, 32'h0098_967F};
        vt[4] = '{1'b1, 1'b1, 32'h8000_0000, 1'b1, 32'h8098_9680};
        vt[5] = '{1'b1, 1'b1, 32'h7F67_697F, 1'b1, 32'h7FFF_FFFF};
        vt[6] = '{1'b1, 1'b1, 32'h7F67_6980, 1'b1, 32'h7FFF_FFFF};
        bus.audio_in_available  = 1'b0;
        bus.audio_out_allowed   = 1'b0;
        bus.left_in             = 32'd123;
        bus.right_in            = 32'hFFFF_FFFB;
        bus2.audio_in_available = 1'b1;
        bus2.audio_out_allowed  = 1'b1;
        bus2.left_in            = '0;
        bus2.right_in           = '0;
        model_reset();
        #12;
        check_all();
        resetn = 1'b1;

        // two voices, same pitch, simultaneous trig
        bus.audio_in_available = 1'b1;
        bus.audio_out_allowed  = 1'b1;
        bus.left_in  = '0;
        bus.right_in = '0;
        sel  = 8'h11;
        trig = 2'b11;
        step();
        step();
        chk("dual_first", bus.left_out, 32'd20000000);
        repeat (21) step();
        chk("dual_last_high", bus.left_out, 32'd20000000);
        step();
        chk("dual_low", bus.left_out, 32'hFECE_D300);
        sel = '0;
        step();

        // retrigger at phase 100 restarts the half-period with sq high
        sel  = 8'h0F;
        trig = 2'b01;
        step();
        repeat (100) step();
        trig = 2'b01;
        step();
        repeat (200) step();
        chk("retrig_hold", bus.left_out, 32'd10000000);

        for (int i = 0; i < 7; i++) begin
            bus.audio_in_available = vt[i].av;
            bus.audio_out_allowed  = vt[i].al;
            bus.left_in  = vt[i].lin;
            bus.right_in = vt[i].lin;
            #1;
            chk("vec_hs", bus.read_audio_in, vt[i].exp_hs);
            chk("vec_left", bus.left_out, vt[i].exp_out);
            chk("vec_right", bus.right_out, vt[i].exp_out);
            step();
        end

        // negative saturation once the square is low
        bus.left_in = '0;
        repeat (45) step();
        chk("neg_amp", bus.left_out, 32'hFF67_6980);
        bus.left_in = 32'h8000_0000;
        #1 chk("neg_sat", bus.left_out, 32'h8000_0000);
        bus.left_in = 32'h8098_9680;
        #1 chk("neg_edge", bus.left_out, 32'h8000_0000);
        bus.left_in = 32'h8098_9681;
        #1 chk("neg_edge1", bus.left_out, 32'h8000_0001);
        sel = '0;
        step();

        // asynchronous reset in the middle of a tone
        sel  = 8'h0F;
        trig = 2'b01;
        repeat (3) step();
        bus.left_in = 32'h1234;
        #2 resetn = 1'b0;
        #1;
        model_reset();
        chk("rst_active", act, 2'b00);
        chk("rst_left", bus.left_out, 32'h1234);
        chk("rst_right", bus.right_out, bus.right_in);
        @(posedge clk);
        #1 resetn = 1'b1;
        sel = '0;
        step();

        // duration: active exactly dur clocks; later dur changes ignored
        bus.left_in = 32'd777;
        sel  = 8'h02;
        dur  = 26'd1000;
        trig = 2'b01;
        step();
        dur = 26'd5;
        cnt = 0;
        while (act[0] && cnt < 2000) begin
            cnt++;
            step();
        end
        chk("dur_len", cnt, 1000);
        step();
        chk("dur_silent", bus.left_out, 32'd777);
        sel = '0;
        step();

        for (int c = 0; c < 600; c++) begin
            bus.audio_in_available = 1'($urandom_range(1, 0));
            bus.audio_out_allowed  = 1'($urandom_range(1, 0));
            r = $urandom;
            bus.left_in  = (r[1:0] == 2'd0) ? 32'h7FFF_FFFF - $urandom_range(50000000, 0) :
                           (r[1:0] == 2'd1) ? 32'h8000_0000 + $urandom_range(50000000, 0) : $urandom;
            bus.right_in = (r[3:2] == 2'd0) ? 32'h7FFF_FFFF - $urandom_range(50000000, 0) : $urandom;
            dur = 26'($urandom_range(80, 0));
            for (int i = 0; i < 2; i++) begin
                if ($urandom_range(15, 0) == 0) begin
                    sel[i*4 +: 4] = 4'($urandom_range(3, 0));
                    trig[i] = 1'b1;
                end else if ($urandom_range(40, 0) == 0) sel[i*4 +: 4] = '0;
            end
            step();
        end

        // full-size pitch: sel=1 with BASE_HALF=3000 holds each level 35769 clocks
        sel2  = 8'h01;
        trig2 = 2'b01;
        @(posedge clk);
        #1 trig2 = '0;
        @(posedge clk);
        #1 chk("tone2_first", bus2.left_out, 32'd10000000);
        cnt = 1;
        while (bus2.left_out == 32'd10000000 && cnt < 40000) begin
            @(posedge clk);
            #1 cnt++;
        end
        chk("tone2_half", cnt - 1, 35769);
        chk("tone2_low", bus2.left_out, 32'hFF67_6980);
        chk("tone2_active", act2, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
